// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the instruction memory, buffers {pc, inst} pairs, hands them to decode.
// Optional fetch_cnt output (handshake pop counter) is enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   inst_buf_q [DEPTH];
  logic [31:0]   pc_buf_q   [DEPTH];
  logic          pop, push;

  assign if_valid  = (count_q != '0);
  assign pop       = if_valid & if_ready;
  assign if_inst   = if_valid ? inst_buf_q[head_q] : NOP_INST;
  assign if_pc     = if_valid ? pc_buf_q[head_q] : '0;
  assign imem_addr = {2'b00, pc_q[31:2]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (halt_req) state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = BOOT;
      endcase
    end
  end

  // A full buffer may still fetch when the head leaves in the same cycle.
  always_comb begin
    imem_en = (state_q == RUN) & ~redirect_valid & ~halt_req & ((count_q < FULL) | pop);
    push    = imem_en;
  end

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h3;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) head_d = head_q + PW'(1);
      if (push) begin
        tail_d = tail_q + PW'(1);
        pc_d   = pc_q + 32'd4;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC & ~32'h3;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_buf_q[tail_q] <= imem_inst;
      pc_buf_q[tail_q]   <= pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      fetch_cnt_q <= '0;
    else if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0 and FFFF_FFF8) under shared stimulus,
// checked every cycle against a queue-based model plus directed literal expectations.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, halt_req, if_ready;
  logic [31:0] redirect_pc;

  logic        en0, en1, val0, val1;
  logic [31:0] addr0, addr1, imi0, imi1, inst0, inst1, ipc0, ipc1;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fc0, fc1;
`endif

  assign imi0 = 32'hA000_0000 | addr0;
  assign imi1 = 32'hA000_0000 | addr1;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .NOP_INST(32'h0000_0013)) dut0 (
    .clk(clk), .rst(rst), .imem_en(en0), .imem_addr(addr0), .imem_inst(imi0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(val0), .if_ready(if_ready), .if_inst(inst0), .if_pc(ipc0)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fc0)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .NOP_INST(32'h0000_0013)) dut1 (
    .clk(clk), .rst(rst), .imem_en(en1), .imem_addr(addr1), .imem_inst(imi1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(val1), .if_ready(if_ready), .if_inst(inst1), .if_pc(ipc1)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fc1)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  localparam int ST_BOOT = 0, ST_RUN = 1, ST_HALT = 2;

  ent_t        mq [2][$];
  logic [31:0] m_pc  [2];
  int          m_st  [2];
  logic [31:0] m_cnt [2];
  bit          known = 1'b0;

  logic        s_en [2], s_val [2];
  logic [31:0] s_addr [2], s_inst [2], s_pc [2], s_fc [2];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] reset_pc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h", nm, i, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit rd, input logic [31:0] rp, input bit h, input bit rdy);
    bit          e_en [2], e_pop [2], e_val [2];
    ent_t        hd;
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rp; halt_req = h; if_ready = rdy;
    #1;
    s_en[0] = en0;  s_val[0] = val0;  s_addr[0] = addr0;  s_inst[0] = inst0;  s_pc[0] = ipc0;
    s_en[1] = en1;  s_val[1] = val1;  s_addr[1] = addr1;  s_inst[1] = inst1;  s_pc[1] = ipc1;
`ifdef IFU_PERF_CNT_EN
    s_fc[0] = fc0;  s_fc[1] = fc1;
`else
    s_fc[0] = '0;   s_fc[1] = '0;
`endif
    for (int i = 0; i < 2; i++) begin
      e_val[i] = (mq[i].size() != 0);
      hd       = e_val[i] ? mq[i][0] : '{pc: 32'h0, inst: 32'h0000_0013};
      e_pop[i] = e_val[i] && rdy;
      e_en[i]  = (m_st[i] == ST_RUN) && !rd && !h && ((mq[i].size() < 2) || e_pop[i]);
      if (known) begin
        chk("imem_en",   i, 32'(s_en[i]),  32'(e_en[i]));
        chk("imem_addr", i, s_addr[i],     m_pc[i] >> 2);
        chk("if_valid",  i, 32'(s_val[i]), 32'(e_val[i]));
        chk("if_inst",   i, s_inst[i],     hd.inst);
        chk("if_pc",     i, s_pc[i],       hd.pc);
`ifdef IFU_PERF_CNT_EN
        chk("fetch_cnt", i, s_fc[i],       m_cnt[i]);
`endif
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mq[i].delete();
        m_pc[i]  = reset_pc(i) & ~32'h3;
        m_st[i]  = ST_BOOT;
        m_cnt[i] = 32'h0;
      end else if (known) begin
        if (e_pop[i]) m_cnt[i] = m_cnt[i] + 32'd1;
        if (rd) begin
          mq[i].delete();
          m_pc[i] = rp & ~32'h3;
          m_st[i] = ST_RUN;
        end else begin
          if (e_pop[i]) void'(mq[i].pop_front());
          if (e_en[i]) begin
            mq[i].push_back('{pc: m_pc[i], inst: 32'hA000_0000 | (m_pc[i] >> 2)});
            m_pc[i] = m_pc[i] + 32'd4;
          end
          if (m_st[i] == ST_BOOT)              m_st[i] = ST_RUN;
          else if (m_st[i] == ST_RUN && h)     m_st[i] = ST_HALT;
        end
      end
    end
    if (r) known = 1'b1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; if_ready = 1'b1;

    // Reset values and basic fetch / wrap
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("rst_en",   0, 32'(s_en[0]),  32'h0);
    chk("rst_addr", 0, s_addr[0],     32'h0);
    chk("rst_addr", 1, s_addr[1],     32'h3FFF_FFFE);
    chk("rst_val",  0, 32'(s_val[0]), 32'h0);
    chk("rst_inst", 0, s_inst[0],     32'h0000_0013);
    chk("rst_pc",   0, s_pc[0],       32'h0);
    cycle(0, 0, 0, 0, 1);
    chk("boot_en", 0, 32'(s_en[0]), 32'h0);
    chk("boot_en", 1, 32'(s_en[1]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 1);
      chk("fetch_addr", 0, s_addr[0], 32'(k));
      chk("fetch_en",   0, 32'(s_en[0]), 32'h1);
      if (k < 3) chk("wrap_addr", 1, s_addr[1], (32'h3FFF_FFFE + 32'(k)) & 32'h3FFF_FFFF);
      if (k >= 1) begin
        chk("fetch_pc",   0, s_pc[0],   32'(4 * (k - 1)));
        chk("fetch_inst", 0, s_inst[0], 32'hA000_0000 | 32'(k - 1));
      end
    end

    // Backpressure
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      cycle(0, 0, 0, 0, 0);
      if (j == 0) chk("bp_addr1", 0, s_addr[0], 32'h1);
      else begin
        chk("bp_en",   0, 32'(s_en[0]), 32'h0);
        chk("bp_addr", 0, s_addr[0],    32'h2);
      end
      chk("bp_val", 0, 32'(s_val[0]), 32'h1);
      chk("bp_pc",  0, s_pc[0],       32'h0);
    end
    for (int j = 0; j < 3; j++) begin
      cycle(0, 0, 0, 0, 1);
      chk("rel_val", 0, 32'(s_val[0]), 32'h1);
      chk("rel_pc",  0, s_pc[0],       32'(4 * j));
    end

    // Redirect with two entries buffered
    cycle(0, 1, 32'h0000_0047, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("rd_val",  0, 32'(s_val[0]), 32'h0);
    chk("rd_addr", 0, s_addr[0],     32'h11);
    cycle(0, 0, 0, 0, 1);
    chk("rd_pc",   0, s_pc[0],       32'h44);
    chk("rd_inst", 0, s_inst[0],     32'hA000_0011);

    // Halt then resume
    cycle(0, 0, 0, 1, 0);
    for (int j = 0; j < 10; j++) begin
      cycle(0, 0, 0, (j % 3) == 0, 1);
      chk("halt_en", 0, 32'(s_en[0]), 32'h0);
    end
    chk("halt_drained", 0, 32'(s_val[0]), 32'h0);
    cycle(0, 1, 32'h0000_0100, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("resume_addr", 0, s_addr[0],    32'h40);
    chk("resume_en",   0, 32'(s_en[0]), 32'h1);

    // Five pops then a redirect that flushes one entry
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    for (int j = 0; j < 6; j++) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'h0000_0200, 0, 0);
    cycle(0, 0, 0, 0, 0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_cnt", 0, s_fc[0], 32'd5);
    chk("perf_cnt", 1, s_fc[1], 32'd5);
`endif

    // Mid-stream reset on the wrapping instance
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("mrst_val", 1, 32'(s_val[1]), 32'h0);
    chk("mrst_en",  1, 32'(s_en[1]),  32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("mrst_cnt", 0, s_fc[0], 32'h0);
`endif
    cycle(0, 0, 0, 0, 1);
    chk("mrst_addr", 1, s_addr[1],    32'h3FFF_FFFE);
    chk("mrst_en1",  1, 32'(s_en[1]), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester end of the instruction-memory interface. Drives `im`'s en/address and captures inst_out.
- Holds the program counter and a small fetch buffer, and presents {pc, instruction} pairs to decode over a valid/ready handshake.
- Supports branch/jump redirect and a halt request.
- Sits between the `im` instruction memory and the decode stage of the RISC-V core.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] ignored.
- DEPTH, 2, fetch-buffer entries; power of two, at least 2.
- NOP_INST, 32'h0000_0013, value driven on if_inst while the buffer is empty (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_en  out  1  read enable to `im`.
- imem_addr  out  32  word address to `im` = {2'b00, pc[31:2]}.
- imem_inst  in  32  instruction from `im`; combinational, valid in the same cycle as en/address.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  32  new byte PC; bits [1:0] forced to 0.
- halt_req  in  1  stop fetching (ecall/ebreak/fault from later stages).
- if_valid  out  1  buffer head valid.
- if_ready  in  1  decode accepts the head.
- if_inst  out  32  head instruction.
- if_pc  out  32  head byte PC.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and has highest priority.
- Reset values:
  - pc = RESET_PC & ~3; buffer empty; state = BOOT.
  - imem_en = 0, imem_addr = {2'b00, RESET_PC[31:2]}.
  - if_valid = 0, if_inst = NOP_INST, if_pc = 0.
- FSM states: BOOT, RUN, HALTED.
  - BOOT -> RUN unconditionally after one cycle. No fetch is issued in BOOT.
  - RUN -> HALTED on halt_req = 1 when redirect_valid = 0.
  - HALTED -> RUN only on redirect_valid = 1. halt_req is ignored while in HALTED.
  - RUN or HALTED -> RUN on redirect_valid = 1.
- Handshake signals:
  - pop = if_valid & if_ready.
  - if_valid = (count != 0); if_inst and if_pc are the head entry.
  - Head outputs are stable while if_valid = 1 and if_ready = 0.
- Fetch enable: imem_en = (state == RUN) & !redirect_valid & !halt_req & (count < DEPTH | pop).
  - This is combinational from state, count, redirect_valid, halt_req and if_ready.
- Push: on a clk edge with imem_en = 1:
  - push {pc, imem_inst} to the tail;
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Latency: an instruction fetched in cycle N is presented on if_valid in cycle N+1. Sustained throughput is one instruction per cycle while if_ready = 1.
- Simultaneous push and pop: count is unchanged and ordering is strictly FIFO. When the buffer is full, a push proceeds only if the head pops in the same cycle.
- Redirect (priority below rst, above everything else):
  - All entries are flushed, count <= 0.
  - pc <= redirect_pc & ~3; state <= RUN.
  - A head that pops in the same cycle counts as delivered to decode. No fetch occurs in the redirect cycle.
  - The first fetch of the target happens in the next cycle and appears at if_valid one cycle after that.
- Halt:
  - pc holds. Buffered entries continue to drain to decode.
  - imem_en stays 0 until a redirect.
- Reset mid-operation: all state is discarded on the rst edge, regardless of the handshake.
- Buffer behaviour: full and empty are never overrun or underrun. There are no duplicate or dropped instructions, except those flushed by a redirect.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds output port fetch_cnt [31:0], counting handshake pops (instructions delivered to decode).
  - Reset to 0; increments by 1 per pop; wraps at 2^32; unaffected by redirect or halt.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Basic fetch: RESET_PC = 0, imem model returns inst = 32'hA000_0000 | word addr, if_ready = 1, rst released.
  - Cycle 0 (BOOT): imem_en = 0.
  - Following cycles: imem_addr = 0, 1, 2, 3.
  - if_pc = 0, 4, 8, 12 with if_inst = A0000000, A0000001, ... each one cycle later.
- Backpressure: if_ready = 0 for 6 cycles after the first push.
  - Buffer fills to 2; imem_en drops to 0 with imem_addr held at 2.
  - if_pc = 0 stays stable.
  - On release: if_pc = 0, 4, 8 in order, with no gap or duplicate.
- Redirect: with 2 entries buffered, redirect_valid = 1 and redirect_pc = 32'h0000_0047.
  - Next cycle: if_valid = 0 and imem_addr = 32'h11.
  - Cycle after: if_pc = 32'h44.
- Halt then resume: halt_req pulse in RUN.
  - Buffered entries drain; imem_en stays 0 for 10 cycles; halt_req during HALTED has no effect.
  - redirect_pc = 32'h100: fetch resumes with imem_addr = 32'h40.
- Wrap and reset: RESET_PC = 32'hFFFF_FFF8.
  - imem_addr = 32'h3FFF_FFFE, 32'h3FFF_FFFF, 0.
  - Mid-stream rst = 1: next cycle if_valid = 0 and imem_en = 0; restart from 32'h3FFF_FFFE.
- IFU_PERF_CNT_EN defined: 5 pops plus 1 redirect that flushes 1 entry.
  - fetch_cnt = 5.
  - After rst: fetch_cnt = 0.
